// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the sensor, classifies the coin and
// accumulates credit, pulsing coin_inserted when credit first reaches PRICE.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PRICE           = 100,
    parameter int unsigned MAX_CREDIT      = 150,
    parameter int unsigned CREDIT_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_sense,
    input  logic [1:0]          coin_type,
    input  logic                credit_clear,
    output logic                coin_inserted,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                credit_ready
);

    localparam int unsigned SumW = CREDIT_W + 1;
    localparam logic [3:0]          DebLast  = 4'(DEBOUNCE_CYCLES);
    localparam logic [SumW-1:0]     MaxSum   = SumW'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PriceVal = CREDIT_W'(PRICE);

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StAccept,
        StWaitRelease
    } state_e;

    logic                sync_meta_q;
    logic                s_sync_q;
    state_e              state_q, state_d;
    logic [3:0]          count_q, count_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                inserted_q, inserted_d;
    logic                reject_q, reject_d;

    logic [CREDIT_W-1:0] base_credit;
    logic [SumW-1:0]     coin_value;
    logic                coin_valid;
    logic [SumW-1:0]     sum;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_meta_q <= 1'b0;
            s_sync_q    <= 1'b0;
            state_q     <= StIdle;
            count_q     <= 4'd0;
            credit_q    <= '0;
            inserted_q  <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            sync_meta_q <= coin_sense;
            s_sync_q    <= sync_meta_q;
            state_q     <= state_d;
            count_q     <= count_d;
            credit_q    <= credit_d;
            inserted_q  <= inserted_d;
            reject_q    <= reject_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (s_sync_q) begin
                    if (DebLast == 4'd1) begin
                        state_d = StAccept;
                        count_d = 4'd0;
                    end else begin
                        state_d = StDebounce;
                        count_d = 4'd1;
                    end
                end
            end
            StDebounce: begin
                if (!s_sync_q) begin
                    state_d = StIdle;
                    count_d = 4'd0;
                end else if (count_q + 4'd1 == DebLast) begin
                    state_d = StAccept;
                    count_d = 4'd0;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            StAccept: state_d = StWaitRelease;
            StWaitRelease: begin
                // One physical coin yields one accept: hold here until the slot empties.
                if (!s_sync_q) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                count_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        coin_valid = 1'b1;
        unique case (coin_type)
            2'b00:   coin_value = SumW'(5);
            2'b01:   coin_value = SumW'(10);
            2'b10:   coin_value = SumW'(25);
            default: begin
                coin_value = '0;
                coin_valid = 1'b0;
            end
        endcase
    end

    // A clear in the accept cycle empties the accumulator before the coin is added.
    assign base_credit = credit_clear ? '0 : credit_q;
    assign sum         = {1'b0, base_credit} + coin_value;

    always_comb begin
        credit_d   = base_credit;
        inserted_d = 1'b0;
        reject_d   = 1'b0;
        if (state_q == StAccept) begin
            if (!coin_valid || (sum > MaxSum)) begin
                reject_d = 1'b1;
            end else begin
                credit_d   = sum[CREDIT_W-1:0];
                inserted_d = (base_credit < PriceVal) && (sum >= {1'b0, PriceVal});
            end
        end
    end

    assign coin_inserted = inserted_q;
    assign coin_reject   = reject_q;
    assign credit        = credit_q;
    assign credit_ready  = (credit_q >= PriceVal);

    pulses_exclusive: assert property (@(posedge clk) disable iff (!reset)
        !(coin_inserted && coin_reject));

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Upstream front end of vending_machine_controller. It synchronises and debounces the raw coin-slot sensor, classifies the denomination, and accumulates credit in cents. It emits the single-cycle coin_inserted pulse the controller consumes when accumulated credit first reaches PRICE. credit_clear from the controller (after vend or change) empties the accumulator.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised-high cycles required to accept a coin (legal range 1..15)
PRICE, 100, credit in cents at which coin_inserted fires
MAX_CREDIT, 150, credit ceiling; coins that would exceed it are rejected (must be >= PRICE and < 2**CREDIT_W)
CREDIT_W, 8, width of credit accumulator

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk
coin_sense  input  1  raw slot sensor, asynchronous, high while a coin is in the slot
coin_type  input  2  denomination: 00=5, 01=10, 10=25, 11=invalid; stable while coin_sense high
credit_clear  input  1  level, synchronous; zero the credit
coin_inserted  output  1  one-cycle pulse when credit crosses from <PRICE to >=PRICE
coin_reject  output  1  one-cycle pulse when an accepted-by-debounce coin is refused
credit  output  CREDIT_W  current accumulated credit, cents
credit_ready  output  1  level, credit >= PRICE

Behaviour:
- Reset (reset==0 at an edge): credit=0; coin_inserted=0, coin_reject=0, credit_ready=0; FSM=IDLE; debounce count=0; both synchroniser flops=0. Reset mid-debounce or mid-accept aborts with no credit change.
- coin_sense passes through a 2-flop synchroniser (s_sync). The FSM sees only s_sync.
- FSM states: IDLE, DEBOUNCE, ACCEPT, WAIT_RELEASE.
  - IDLE: s_sync=1 -> DEBOUNCE, count=1. If DEBOUNCE_CYCLES==1, go directly to ACCEPT.
  - DEBOUNCE: s_sync=0 -> IDLE, count=0, no effect. Otherwise count+1; on reaching DEBOUNCE_CYCLES -> ACCEPT.
  - ACCEPT: one cycle. Classify raw coin_type, decide, register the result -> WAIT_RELEASE.
  - WAIT_RELEASE: stay while s_sync=1; s_sync=0 -> IDLE. One physical coin yields exactly one accept.
- Latency: coin_sense first sampled high at edge E0 and held. credit, coin_inserted and coin_reject update at edge E(DEBOUNCE_CYCLES+2).
- ACCEPT decision:
  - Compute sum = credit + value in CREDIT_W+1 bits (no wrap).
  - Invalid type -> coin_reject pulse, credit unchanged.
  - sum > MAX_CREDIT -> coin_reject pulse, credit unchanged.
  - Otherwise credit = sum. sum == MAX_CREDIT is accepted.
- coin_inserted: pulse exactly when old credit < PRICE and new credit >= PRICE. No pulse on further coins while already >= PRICE.
- credit_ready: combinational compare of the registered credit (equivalently registered alongside it), always == (credit >= PRICE).
- credit_clear:
  - Alone: credit=0 at the next edge; no pulses.
  - Same cycle as ACCEPT: clear applies first, then the coin is added. Result credit = value (if valid); coin_inserted fires if value >= PRICE; an invalid coin still pulses coin_reject.
- coin_inserted and coin_reject are never high in the same cycle. Each pulse lasts exactly one cycle.

Test Plan:
- Four quarters (coin_type=10, coin_sense high 8 cycles each, low 4): credit 25, 50, 75, 100. coin_inserted pulses once, on the 4th coin at E0+6 of that coin. credit_ready=1 thereafter.
- Glitch: coin_sense high 2 cycles with DEBOUNCE_CYCLES=4 -> credit stays 0, no pulses, FSM back to IDLE. A following clean dime gives credit=10.
- Invalid coin_type=11 with clean 8-cycle pulse at credit=50 -> coin_reject one cycle, credit stays 50, coin_inserted 0.
- Overflow: build credit to 140, insert dime -> credit=150, accepted. Then nickel -> coin_reject, credit stays 150.
- credit_clear asserted on the ACCEPT cycle of a quarter with credit=90 -> credit=25, no coin_inserted. Separately, credit_clear alone at credit=100 -> credit=0 next edge, credit_ready=0.
- Reset (reset=0 one cycle) during DEBOUNCE at credit=75 -> credit=0, all outputs 0. Coin held through reset release then produces exactly one accept after a fresh debounce.
